// File: rtl/fuel_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fuel_counter: 3-digit BCD fuel counter with speed-scaled drain,      |
// | refill, low-fuel blink and a sticky EMPTY state.  Rev 1.0            |
// +----------------------------------------------------------------------+
module fuel_counter #(
  parameter logic [11:0] INIT_VALUE    = 12'h100,
  parameter int          REFILL_TENS   = 2,
  parameter logic [11:0] LOW_THRESHOLD = 12'h020,
  parameter int          BLINK_TICKS   = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       addFuel,
  input  logic       restart,
  output logic [3:0] Units,
  output logic [3:0] Tens,
  output logic [3:0] Hundreds,
  output logic       lowFuel,
  output logic       lowBlink,
  output logic       fuelEmpty
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_EMPTY = 1'b1} state_t;

  localparam int          c_cw     = $clog2(BLINK_TICKS + 1);
  localparam logic [4:0]  c_refill = 5'(REFILL_TENS);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_u, r_t, r_h;
  logic [3:0]       w_u_nxt, w_t_nxt, w_h_nxt;
  logic [c_cw-1:0]  r_cnt;
  logic             r_blink;

  logic [3:0] w_drain, w_u_sub, w_t_sub, w_h_sub, w_t_add;
  logic       w_b1, w_b2, w_floor, w_carry;
  logic [4:0] w_t_sum, w_h_sum;
  logic [3:0] w_u_run, w_t_run, w_h_run;
  logic       w_low_nxt;

  always_comb begin
    w_drain = enable ? {2'b00, speed} : 4'd0;

    // Drain first: borrow ripples Units -> Tens -> Hundreds, floor at 000.
    if (r_u < w_drain) begin
      w_u_sub = r_u + 4'd10 - w_drain;
      w_b1    = 1'b1;
    end else begin
      w_u_sub = r_u - w_drain;
      w_b1    = 1'b0;
    end
    if (w_b1 && r_t == 4'd0) begin
      w_t_sub = 4'd9;
      w_b2    = 1'b1;
    end else begin
      w_t_sub = r_t - {3'b000, w_b1};
      w_b2    = 1'b0;
    end
    w_floor = w_b2 && (r_h == 4'd0);
    w_h_sub = r_h - {3'b000, w_b2};
    if (w_floor) begin
      w_u_sub = 4'd0;
      w_t_sub = 4'd0;
      w_h_sub = 4'd0;
    end

    // Then refill into Tens, carry into Hundreds, saturate at 999.
    w_t_sum = {1'b0, w_t_sub} + (addFuel ? c_refill : 5'd0);
    if (w_t_sum > 5'd9) begin
      w_t_add = 4'(w_t_sum - 5'd10);
      w_carry = 1'b1;
    end else begin
      w_t_add = w_t_sum[3:0];
      w_carry = 1'b0;
    end
    w_h_sum = {1'b0, w_h_sub} + {4'b0000, w_carry};
    if (w_h_sum > 5'd9) begin
      w_u_run = 4'd9;
      w_t_run = 4'd9;
      w_h_run = 4'd9;
    end else begin
      w_u_run = w_u_sub;
      w_t_run = w_t_add;
      w_h_run = w_h_sum[3:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_u_nxt     = r_u;
    w_t_nxt     = r_t;
    w_h_nxt     = r_h;
    if (restart) begin
      w_state_nxt = ST_RUN;
      {w_h_nxt, w_t_nxt, w_u_nxt} = INIT_VALUE;
    end else if (r_state == ST_RUN) begin
      w_u_nxt = w_u_run;
      w_t_nxt = w_t_run;
      w_h_nxt = w_h_run;
      if ({w_h_run, w_t_run, w_u_run} == 12'h000)
        w_state_nxt = ST_EMPTY;
    end
    w_low_nxt = (w_state_nxt == ST_RUN) &&
                ({w_h_nxt, w_t_nxt, w_u_nxt} < LOW_THRESHOLD);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state           <= ST_RUN;
      {r_h, r_t, r_u}   <= INIT_VALUE;
      r_cnt             <= '0;
      r_blink           <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_u     <= w_u_nxt;
      r_t     <= w_t_nxt;
      r_h     <= w_h_nxt;
      // Blink clears on the same edge lowFuel drops; only ticks seen while low count.
      if (restart || !w_low_nxt) begin
        r_cnt   <= '0;
        r_blink <= 1'b0;
      end else if (enable && lowFuel) begin
        if (r_cnt == c_cw'(BLINK_TICKS - 1)) begin
          r_cnt   <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign Units     = r_u;
  assign Tens      = r_t;
  assign Hundreds  = r_h;
  assign fuelEmpty = (r_state == ST_EMPTY);
  assign lowFuel   = (r_state == ST_RUN) && ({r_h, r_t, r_u} < LOW_THRESHOLD);
  assign lowBlink  = r_blink;

endmodule
`default_nettype wire
